// File: rtl/ysyx_2022040010_wb_commit.sv
// Writeback/commit: merges long-unit and pipeline results onto the single GPR write port, 1-cycle registered.
// Long unit has fixed priority; pipeline results wait on WAW busy bits; stall_wb freezes the output stage.
module ysyx_2022040010_wb_commit #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_wb,
  input  logic            p_valid,
  input  logic            p_we,
  input  logic [AW-1:0]   p_waddr,
  input  logic [XLEN-1:0] p_wdata,
  output logic            p_ready,
  input  logic            l_valid,
  input  logic [AW-1:0]   l_waddr,
  input  logic [XLEN-1:0] l_wdata,
  output logic            l_ready,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_set_addr,
  input  logic [AW-1:0]   sb_raddr1,
  input  logic [AW-1:0]   sb_raddr2,
  output logic            sb_busy1,
  output logic            sb_busy2,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            commit_valid,
  output logic [63:0]     commit_cnt
);

  logic            r_wb_valid;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_busy;
  logic [63:0]     r_commit_cnt;

  logic            w_waw;
  logic            w_l_acc;
  logic            w_p_acc;
  logic            w_commit;
  logic [NREG-1:0] w_busy_nxt;

  // A pipeline write may not overtake an outstanding long-latency write to the same register.
  always_comb begin
    w_waw    = p_we & (p_waddr != '0) & r_busy[p_waddr];
    w_l_acc  = l_valid & ~stall_wb;
    w_p_acc  = p_valid & ~l_valid & ~stall_wb & ~w_waw;
    w_commit = r_wb_valid & ~stall_wb;
  end

  // Set is applied after clear so a re-issue to the same register stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_l_acc) begin
      w_busy_nxt[l_waddr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != '0)) begin
      w_busy_nxt[sb_set_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else if (!stall_wb) begin
      if (w_l_acc) begin
        r_wb_valid <= 1'b1;
        r_we       <= (l_waddr != '0);
        r_waddr    <= l_waddr;
        r_wdata    <= l_wdata;
      end else if (w_p_acc) begin
        r_wb_valid <= 1'b1;
        r_we       <= p_we & (p_waddr != '0);
        r_waddr    <= p_waddr;
        r_wdata    <= p_wdata;
      end else begin
        r_wb_valid <= 1'b0;
        r_we       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_cnt <= '0;
    end else if (w_commit) begin
      r_commit_cnt <= r_commit_cnt + 64'd1;
    end
  end

  assign p_ready      = w_p_acc;
  assign l_ready      = w_l_acc;
  assign sb_busy1     = r_busy[sb_raddr1];
  assign sb_busy2     = r_busy[sb_raddr2];
  assign we           = r_we;
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;
  assign commit_valid = w_commit;
  assign commit_cnt   = r_commit_cnt;

endmodule

// File: tb/tb_ysyx_2022040010_wb_commit.sv
// Directed bench for the writeback/commit stage: one task per scenario, inline checks.
module tb_ysyx_2022040010_wb_commit;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic            stall_wb;
  logic            p_valid, p_we, p_ready;
  logic [AW-1:0]   p_waddr;
  logic [XLEN-1:0] p_wdata;
  logic            l_valid, l_ready;
  logic [AW-1:0]   l_waddr;
  logic [XLEN-1:0] l_wdata;
  logic            sb_set;
  logic [AW-1:0]   sb_set_addr, sb_raddr1, sb_raddr2;
  logic            sb_busy1, sb_busy2;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            commit_valid;
  logic [63:0]     commit_cnt;

  int errors = 0;
  int checks = 0;

  ysyx_2022040010_wb_commit #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb),
    .p_valid(p_valid), .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_ready(p_ready),
    .l_valid(l_valid), .l_waddr(l_waddr), .l_wdata(l_wdata), .l_ready(l_ready),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_raddr1(sb_raddr1), .sb_raddr2(sb_raddr2),
    .sb_busy1(sb_busy1), .sb_busy2(sb_busy2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .commit_valid(commit_valid), .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_wb = 0; p_valid = 0; p_we = 0; p_waddr = '0; p_wdata = '0;
    l_valid = 0; l_waddr = '0; l_wdata = '0; sb_set = 0; sb_set_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    sb_raddr1 = 5'd1; sb_raddr2 = 5'd2;
    rst = 0;
    #3;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", waddr); end
    checks++; if (wdata !== 64'd0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", wdata); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_commit_valid: got %b want 0", commit_valid); end
    checks++; if (commit_cnt !== 64'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", commit_cnt); end
    checks++; if ({sb_busy1, sb_busy2} !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b want 00", {sb_busy1, sb_busy2}); end
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_pipe_write();
    p_valid = 1; p_we = 1; p_waddr = 5'd3; p_wdata = 64'h1234;
    #1;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL pw_p_ready: got %b want 1", p_ready); end
    checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL pw_l_ready: got %b want 0", l_ready); end
    tick();
    idle();
    checks++; if ({we, waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL pw_we_waddr: got %b/%0d want 1/3", we, waddr); end
    checks++; if (wdata !== 64'h1234) begin errors++; $display("FAIL pw_wdata: got %0h want 1234", wdata); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL pw_commit_valid: got %b want 1", commit_valid); end
    tick();
    checks++; if (commit_cnt !== 64'd1) begin errors++; $display("FAIL pw_cnt: got %0d want 1", commit_cnt); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL pw_we_after: got %b want 0", we); end
  endtask

  task automatic test_collision();
    p_valid = 1; p_we = 1; p_waddr = 5'd4; p_wdata = 64'h44;
    l_valid = 1; l_waddr = 5'd7; l_wdata = 64'h77;
    #1;
    checks++; if ({l_ready, p_ready} !== 2'b10) begin errors++; $display("FAIL col_ready: got l/p=%b want 10", {l_ready, p_ready}); end
    tick();
    l_valid = 0;
    checks++; if ({we, waddr, wdata} !== {1'b1, 5'd7, 64'h77}) begin errors++; $display("FAIL col_first: got %b/%0d/%0h want 1/7/77", we, waddr, wdata); end
    #1;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL col_p_ready2: got %b want 1", p_ready); end
    tick();
    idle();
    checks++; if ({we, waddr, wdata} !== {1'b1, 5'd4, 64'h44}) begin errors++; $display("FAIL col_second: got %b/%0d/%0h want 1/4/44", we, waddr, wdata); end
    tick();
    checks++; if (commit_cnt !== 64'd3) begin errors++; $display("FAIL col_cnt: got %0d want 3", commit_cnt); end
  endtask

  task automatic test_waw_block();
    sb_set = 1; sb_set_addr = 5'd9; sb_raddr1 = 5'd9;
    tick();
    sb_set = 0;
    checks++; if (sb_busy1 !== 1'b1) begin errors++; $display("FAIL waw_busy_set: got %b want 1", sb_busy1); end
    p_valid = 1; p_we = 1; p_waddr = 5'd9; p_wdata = 64'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL waw_hold%0d: p_ready got %b want 0", i, p_ready); end
      tick();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL waw_no_write%0d: we got %b want 0", i, we); end
    end
    l_valid = 1; l_waddr = 5'd9; l_wdata = 64'h55;
    #1;
    checks++; if ({l_ready, p_ready} !== 2'b10) begin errors++; $display("FAIL waw_l_acc: got l/p=%b want 10", {l_ready, p_ready}); end
    tick();
    l_valid = 0;
    checks++; if ({we, waddr, wdata} !== {1'b1, 5'd9, 64'h55}) begin errors++; $display("FAIL waw_l_write: got %b/%0d/%0h want 1/9/55", we, waddr, wdata); end
    checks++; if (sb_busy1 !== 1'b0) begin errors++; $display("FAIL waw_busy_clr: got %b want 0", sb_busy1); end
    #1;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL waw_p_drain: got %b want 1", p_ready); end
    tick();
    idle();
    checks++; if ({we, waddr, wdata} !== {1'b1, 5'd9, 64'h99}) begin errors++; $display("FAIL waw_p_write: got %b/%0d/%0h want 1/9/99", we, waddr, wdata); end
    tick();
    checks++; if (commit_cnt !== 64'd5) begin errors++; $display("FAIL waw_cnt: got %0d want 5", commit_cnt); end
  endtask

  task automatic test_stall();
    p_valid = 1; p_we = 1; p_waddr = 5'd2; p_wdata = 64'h77;
    tick();
    stall_wb = 1;
    p_waddr = 5'd12; p_wdata = 64'hC;
    l_valid = 1; l_waddr = 5'd13; l_wdata = 64'hD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd2, 64'h77}) begin errors++; $display("FAIL st_hold%0d: got %b/%0d/%0h want 1/2/77", i, we, waddr, wdata); end
      checks++; if ({p_ready, l_ready, commit_valid} !== 3'b000) begin errors++; $display("FAIL st_ctrl%0d: p/l/cv got %b want 000", i, {p_ready, l_ready, commit_valid}); end
      checks++; if (commit_cnt !== 64'd5) begin errors++; $display("FAIL st_cnt%0d: got %0d want 5", i, commit_cnt); end
      if (i < 2) tick();
    end
    idle();
    #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL st_release_cv: got %b want 1", commit_valid); end
    tick();
    checks++; if ({we, commit_cnt} !== {1'b0, 64'd6}) begin errors++; $display("FAIL st_release: we/cnt got %b/%0d want 0/6", we, commit_cnt); end
    tick();
    checks++; if (commit_cnt !== 64'd6) begin errors++; $display("FAIL st_single: got %0d want 6", commit_cnt); end
  endtask

  task automatic test_x0_race();
    p_valid = 1; p_we = 1; p_waddr = 5'd0; p_wdata = 64'hDEAD;
    sb_set = 1; sb_set_addr = 5'd0; sb_raddr1 = 5'd0;
    tick();
    idle();
    checks++; if ({we, commit_valid} !== 2'b01) begin errors++; $display("FAIL x0_write: we/cv got %b want 01", {we, commit_valid}); end
    checks++; if (sb_busy1 !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", sb_busy1); end
    sb_set = 1; sb_set_addr = 5'd6; sb_raddr2 = 5'd6;
    l_valid = 1; l_waddr = 5'd6; l_wdata = 64'h66;
    tick();
    idle();
    checks++; if (sb_busy2 !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b want 1", sb_busy2); end
    checks++; if ({we, waddr, wdata} !== {1'b1, 5'd6, 64'h66}) begin errors++; $display("FAIL race_write: got %b/%0d/%0h want 1/6/66", we, waddr, wdata); end
    checks++; if (commit_cnt !== 64'd7) begin errors++; $display("FAIL race_cnt: got %0d want 7", commit_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    p_valid = 1; p_we = 1; p_waddr = 5'd5; p_wdata = 64'hAA;
    sb_raddr2 = 5'd6;
    #1;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL rmw_accept: got %b want 1", p_ready); end
    #1;
    rst = 0;
    #1;
    checks++; if ({we, commit_cnt} !== {1'b0, 64'd0}) begin errors++; $display("FAIL rmw_immediate: we/cnt got %b/%0d want 0/0", we, commit_cnt); end
    checks++; if (sb_busy2 !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b want 0", sb_busy2); end
    idle();
    #1;
    rst = 1;
    tick();
    checks++; if ({we, waddr, commit_valid} !== {1'b0, 5'd0, 1'b0}) begin errors++; $display("FAIL rmw_dropped: we/waddr/cv got %b/%0d/%b want 0/0/0", we, waddr, commit_valid); end
    tick();
    checks++; if (commit_cnt !== 64'd0) begin errors++; $display("FAIL rmw_cnt: got %0d want 0", commit_cnt); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_collision();
    test_waw_block();
    test_stall();
    test_x0_race();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_wb_commit.md
Name: ysyx_2022040010_wb_commit

Overview:
- Writeback/commit stage: the single producer for the GPR file's write port (we/waddr/wdata).
- Merges two result sources into that one write port:
  - the in-order pipeline result (MEM/WB, one result per instruction);
  - a long-latency unit result (mul/div, completes out of band).
- Keeps a per-register busy scoreboard for outstanding long-latency destinations. Decode uses it for RAW stalls; this block uses it to prevent WAW clobbering.
- Produces commit pulses and a retired-instruction count for difftest.

Parameters:
- XLEN, 64, data width of results and write data.
- NREG, 32, number of GPRs.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_wb  in  1  writeback stall, same bit the regfile honours (stall[3]); high = hold.
- p_valid  in  1  pipeline result valid.
- p_we  in  1  pipeline result writes a GPR.
- p_waddr  in  AW  pipeline destination.
- p_wdata  in  XLEN  pipeline result.
- p_ready  out  1  pipeline result accepted this cycle (combinational).
- l_valid  in  1  long-unit result valid.
- l_waddr  in  AW  long-unit destination.
- l_wdata  in  XLEN  long-unit result.
- l_ready  out  1  long-unit result accepted this cycle (combinational).
- sb_set  in  1  decode issued a long-latency op this cycle.
- sb_set_addr  in  AW  its destination.
- sb_raddr1  in  AW  scoreboard query 1.
- sb_raddr2  in  AW  scoreboard query 2.
- sb_busy1  out  1  busy[sb_raddr1] (combinational).
- sb_busy2  out  1  busy[sb_raddr2] (combinational).
- we  out  1  regfile write enable (registered).
- waddr  out  AW  regfile write address (registered).
- wdata  out  XLEN  regfile write data (registered).
- commit_valid  out  1  an instruction retires this cycle (combinational: wb_valid & ~stall_wb).
- commit_cnt  out  64  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_valid=0, we=0, waddr=0, wdata=0.
  - busy[] all 0, commit_cnt=0.
  - Combinational outputs follow from that state: commit_valid=0, sb_busy*=0.
  - Takes effect immediately, mid-transaction included. Any in-flight output write is dropped.
- Output stage registers: wb_valid, we, waddr, wdata.
  - Latency: exactly 1 clk from acceptance to the write appearing on we/waddr/wdata.
  - The regfile commits the write on the following edge and bypasses it to its readers in the meantime.
- Acceptance, evaluated each cycle with stall_wb=0:
  1. l_valid=1: l_ready=1, p_ready=0. Load wb_valid=1, we=(l_waddr!=0), waddr=l_waddr, wdata=l_wdata. Long unit has fixed priority.
  2. Else if p_valid=1 and no WAW hazard: p_ready=1. Load wb_valid=1, we=p_we&(p_waddr!=0), waddr=p_waddr, wdata=p_wdata.
     - WAW hazard = p_we & (p_waddr!=0) & busy[p_waddr].
  3. Else: p_ready=0, l_ready=0. Load wb_valid=0, we=0; waddr/wdata hold.
- stall_wb=1:
  - p_ready=0, l_ready=0.
  - All output registers hold, so a pending write re-presents to the regfile and lands on the first unstalled edge.
  - commit_valid=0; commit_cnt holds.
- commit_cnt increments by 1 on every edge where commit_valid=1. Wraps modulo 2^64.
- Scoreboard:
  - busy[0] is hardwired 0.
  - Set: sb_set=1 and sb_set_addr!=0 sets busy[sb_set_addr] on the edge.
  - Clear: l_valid & l_ready clears busy[l_waddr] on the edge.
  - Same address set and cleared on the same edge: set wins (new op outstanding).
  - sb_set is honoured regardless of stall_wb.
  - l_valid for a register whose busy bit is 0 is still written; the clear is a no-op.
  - sb_busy1/2: pure combinational reads of the current busy[] (no bypass of same-cycle set/clear).
- No deadlock: the long port is never blocked by the scoreboard, so a pipeline result stalled on WAW always drains once the matching long result arrives.

Test Plan:
- Reset mid-write: drive an accepted p write {p_waddr=5, p_wdata=0xAA}. Assert rst=0 before the next edge -> we=0, commit_cnt=0, busy all 0 immediately; after release, nothing is written to x5.
- Pipeline write: p_valid=1, p_we=1, p_waddr=3, p_wdata=0x1234 at cycle t -> p_ready=1 at t; we=1, waddr=3, wdata=0x1234 at t+1; commit_valid=1 at t+1; commit_cnt +1.
- Collision: p_valid=1 and l_valid=1 in the same cycle (x4, x7) -> l accepted first, p_ready=0. Next cycle the pipe result is accepted. Outputs: x7 then x4 on consecutive cycles.
- WAW block:
  - sb_set for x9 -> sb_busy1 (raddr1=9)=1.
  - p write to x9 is held with p_ready=0 for 3 cycles.
  - l result for x9 (0x55) arrives and is accepted; busy[9]=0.
  - The p write is accepted the next cycle; final x9 holds the p value.
- Stall: accepted write {x2, 0x77}, then stall_wb=1 for 2 cycles -> we/waddr/wdata hold, p_ready=l_ready=0, commit_valid=0, commit_cnt unchanged. Released -> single commit.
- x0 and set/clear race:
  - p write to x0 -> we=0 but commit_valid=1.
  - sb_set for x0 -> busy stays 0.
  - sb_set for x6 on the same edge as an l result for x6 -> busy[6]=1 afterwards.
